ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
//  Feeds the configuration-chain head (ccff_head) of a routing tile (connection/switch block). Accepts
//  bitstream words over a valid/ready handshake and serialises them MSB-first onto ccff_head. Drives
//  config_enable only on shift cycles and counts exactly CHAIN_LEN bits. Captures the bits that fall
//  out of ccff_tail as read-back words, so firmware can verify the previous contents.
// PARAMETERS
//  WORD_W     8   bitstream/read-back word width
//  CHAIN_LEN  36  total chain bits (default: 9 mux mems x 4 bits); must be >= 1
//  CNT_W      16  bit-counter width; CHAIN_LEN < 2**CNT_W
// PORTS
//  prog_clk    in   1       programming clock; the only clock
//  pReset      in   1       synchronous, active-high reset
//  start       in   1       1-cycle pulse; begin a load (ignored unless IDLE)
//  wr_data     in   WORD_W  bitstream word, bit WORD_W-1 shifted first
//  wr_valid    in   1       wr_data valid
//  wr_ready    out  1       loader accepts wr_data this cycle
//  ccff_head   out  1       serial config bit to the chain head
//  config_enable out 1      chain shift enable, high only in shift cycles
//  ccff_tail   in   1       serial bit from the chain tail
//  rb_data     out  WORD_W  read-back word, first tail bit in MSB
//  rb_valid    out  1       1-cycle strobe, rb_data valid
//  busy        out  1       load in progress
//  done        out  1       1-cycle pulse, last chain bit shifted
// BEHAVIOUR
//  - All outputs registered. Reset (pReset=1 at a prog_clk edge) -> state IDLE; all outputs 0,
//    bit counter 0, shift and read-back registers 0. Reset mid-load aborts immediately; no further
//    shift cycles occur. Chain contents are then undefined and must be reloaded.
//  - States: IDLE, FETCH, SHIFT, DONE.
//  - IDLE: start=1 -> FETCH, busy=1 from the next cycle, bit counter cleared.
//  - FETCH: wr_ready=1. Handshake completes when wr_valid && wr_ready at an edge. The word is
//    loaded into the shift register, nbits = min(WORD_W, CHAIN_LEN - count), and the state goes
//    to SHIFT. wr_ready is 0 in every other state.
//  - SHIFT: each cycle config_enable=1 and ccff_head=current MSB. The chain captures on the edge
//    ending that cycle. On the same edge: ccff_tail is sampled into the read-back register
//    (shift-left, LSB in), count++, and the shift register shifts left.
//    * After nbits cycles, if count==CHAIN_LEN -> DONE; else -> FETCH.
//    * Between words, config_enable=0 for at least the one FETCH cycle; the chain holds.
//  - Read-back: rb_valid pulses once per word, the cycle after that word's last shift.
//    * Full word: rb_data holds the WORD_W tail bits.
//    * Partial final word (nbits<WORD_W): rb_data holds the nbits bits in its low bits, the first
//      tail bit at position nbits-1; upper bits are 0.
//  - Partial final word: only the top nbits of wr_data are shifted; the remaining low bits are
//    discarded.
//  - DONE: done=1 for 1 cycle, busy=0, config_enable=0, ccff_head=0, then IDLE.
//  - start while busy is ignored. wr_valid outside FETCH is ignored; no data is consumed.
//  - Total shift cycles per load = CHAIN_LEN exactly; head/enable glitch-free (registered).
// TESTING
//  1. Reset with pReset=1 for 2 cycles -> all outputs 0, state IDLE; start while pReset=1 is ignored.
//  2. WORD_W=8, CHAIN_LEN=36, words 0xA5,0x3C,0xFF,0x00,0x9 (in high nibble 0x90) -> exactly 36
//     config_enable cycles. Head bit sequence 10100101 00111100 11111111 00000000 1001. done pulses
//     once; the chain model then reads back the same 36 bits.
//  3. Second load after test 2 with all-zero words -> rb_data = 0xA5,0x3C,0xFF,0x00, then 0x09 on
//     the partial word. rb_valid pulses 5 times.
//  4. wr_valid held low 10 cycles in FETCH -> config_enable stays 0 and the chain state is
//     unchanged; the load resumes correctly when wr_valid rises.
//  5. pReset asserted after 13 shift cycles -> the next cycle has busy=0 and config_enable=0; no
//     extra shifts; a new start reloads all 36 bits.
//  6. start pulsed during SHIFT, and wr_valid held high during SHIFT -> no restart, no extra word
//     consumed; the word count and shift count stay correct (5 and 36).

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Feeds the configuration chain head of a routing tile. Bitstream words
//   arrive over a valid/ready handshake and are shifted MSB-first onto
//   ccff_head, with config_enable high only on shift cycles. Exactly
//   CHAIN_LEN bits are shifted per load. Bits falling out of ccff_tail are
//   collected into read-back words so firmware can verify the old contents.
//
// Ports
//   prog_clk      in   programming clock (only clock)
//   pReset        in   synchronous active-high reset
//   start         in   1-cycle pulse, begins a load when idle
//   wr_data       in   bitstream word, MSB shifted first
//   wr_valid      in   wr_data valid
//   wr_ready      out  word accepted this cycle (FETCH only)
//   ccff_head     out  serial config bit to chain head
//   config_enable out  chain shift enable
//   ccff_tail     in   serial bit from chain tail
//   rb_data       out  read-back word, first tail bit in MSB (or bit nbits-1)
//   rb_valid      out  1-cycle strobe for rb_data
//   busy          out  load in progress
//   done          out  1-cycle pulse after the last chain bit
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 36,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  count_reg;     // chain bits shifted so far in this load
  logic [CNT_W-1:0]  remain_reg;    // bits still to shift from the current word
  logic [WORD_W-1:0] shift_reg;     // bits queued behind the one on ccff_head
  logic [WORD_W-1:0] rb_shift_reg;  // tail bits collected for the current word

  logic [CNT_W-1:0]  left_next;
  logic [CNT_W-1:0]  nbits_next;
  logic [WORD_W-1:0] rb_shift_next;
  logic [CNT_W-1:0]  count_next;

  always_comb begin
    left_next     = CHAIN_LEN_C - count_reg;
    nbits_next    = (left_next < WORD_W_C) ? left_next : WORD_W_C;
    // Read-back register is cleared per word, so a partial word naturally
    // lands in the low nbits with the first tail bit at position nbits-1.
    rb_shift_next = {rb_shift_reg[WORD_W-2:0], ccff_tail};
    count_next    = count_reg + CNT_W'(1);
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      remain_reg    <= '0;
      shift_reg     <= '0;
      rb_shift_reg  <= '0;
      wr_ready      <= 1'b0;
      ccff_head     <= 1'b0;
      config_enable <= 1'b0;
      rb_data       <= '0;
      rb_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      done     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= FETCH;
            busy      <= 1'b1;
            wr_ready  <= 1'b1;
            count_reg <= '0;
          end
        end

        FETCH: begin
          if (wr_valid) begin
            // Head and enable are registered here so the first shift cycle
            // already presents the word's MSB; the rest waits in shift_reg.
            state_reg     <= SHIFT;
            wr_ready      <= 1'b0;
            ccff_head     <= wr_data[WORD_W-1];
            shift_reg     <= wr_data << 1;
            config_enable <= 1'b1;
            remain_reg    <= nbits_next;
            rb_shift_reg  <= '0;
          end
        end

        SHIFT: begin
          count_reg    <= count_next;
          remain_reg   <= remain_reg - CNT_W'(1);
          rb_shift_reg <= rb_shift_next;
          shift_reg    <= shift_reg << 1;
          if (remain_reg == CNT_W'(1)) begin
            // Last bit of this word: close the enable window, publish read-back.
            config_enable <= 1'b0;
            ccff_head     <= 1'b0;
            rb_valid      <= 1'b1;
            rb_data       <= rb_shift_next;
            if (count_next == CHAIN_LEN_C) begin
              state_reg <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state_reg <= FETCH;
              wr_ready  <= 1'b1;
            end
          end else begin
            ccff_head <= shift_reg[WORD_W-1];
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;
  localparam int W  = 8;
  localparam int L  = 36;
  localparam int NW = (L + W - 1) / W;

  logic         prog_clk = 1'b0;
  logic         pReset;
  logic         start;
  logic [W-1:0] wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic         ccff_head;
  logic         config_enable;
  logic         ccff_tail;
  logic [W-1:0] rb_data;
  logic         rb_valid;
  logic         busy;
  logic         done;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L), .CNT_W(16)) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .ccff_head    (ccff_head),
    .config_enable(config_enable),
    .ccff_tail    (ccff_tail),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid),
    .busy         (busy),
    .done         (done)
  );

  // Behavioural chain: a plain L-bit shift register clocked when enabled.
  logic [L-1:0] chain = '0;
  always @(posedge prog_clk) if (config_enable) chain <= {chain[L-2:0], ccff_head};
  assign ccff_tail = chain[L-1];

  // Event recorder: what the chain and firmware see at each edge.
  int           en_cnt   = 0;
  int           done_cnt = 0;
  int           acc_cnt  = 0;
  bit           head_q[$];
  logic [W-1:0] rb_q[$];
  always @(posedge prog_clk) begin
    if (config_enable) begin
      head_q.push_back(ccff_head);
      en_cnt <= en_cnt + 1;
    end
    if (rb_valid) rb_q.push_back(rb_data);
    if (done) done_cnt <= done_cnt + 1;
    if (wr_valid && wr_ready) acc_cnt <= acc_cnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] words [NW];
  logic [W-1:0] exp3  [NW];

  // One complete load. gap_word gets a 10-cycle wr_valid stall in FETCH;
  // mischief holds wr_valid high through SHIFT and pulses start; abort_at>0
  // asserts pReset on the edge ending shift number abort_at+1.
  task automatic run_load(input string tag, input bit mischief, input int gap_max,
                          input int gap_word, input int abort_at);
    int en0, dn0, acc0, hq0, rb0, idx, gap, cyc, nb;
    bit hs_pend;
    logic [L-1:0] snap, exp_vec, got_vec;
    logic [W-1:0] exp_rb, got_rb;
    @(negedge prog_clk);
    snap = chain;
    en0 = en_cnt; dn0 = done_cnt; acc0 = acc_cnt;
    hq0 = head_q.size(); rb0 = rb_q.size();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1);
    idx = 0; hs_pend = 0; cyc = 0;
    gap = (gap_word == 0) ? 10 : $urandom_range(gap_max, 0);
    while ((idx < NW || busy) && cyc < 3000) begin
      if (hs_pend) begin
        idx++;
        gap = (idx == gap_word) ? 10 : $urandom_range(gap_max, 0);
      end
      if (abort_at > 0 && en_cnt - en0 == abort_at && config_enable) begin
        pReset = 1'b1; wr_valid = 1'b0; start = 1'b0;
        @(negedge prog_clk);
        chk({tag, " abort_busy"}, busy, 0);
        chk({tag, " abort_enable"}, config_enable, 0);
        chk({tag, " abort_shifts"}, en_cnt - en0, abort_at + 1);
        pReset = 1'b0;
        repeat (5) @(negedge prog_clk);
        chk({tag, " abort_no_more_shifts"}, en_cnt - en0, abort_at + 1);
        chk({tag, " abort_idle"}, {wr_ready, busy}, 2'b00);
        $display("load %s: aborted after %0d shifts", tag, en_cnt - en0);
        return;
      end
      start = mischief && config_enable && ($urandom_range(3, 0) == 0);
      if (wr_ready && idx < NW && !mischief && gap > 0) begin
        gap--; wr_valid = 1'b0; wr_data = W'($urandom);
      end else if (idx < NW && (wr_ready || mischief)) begin
        wr_valid = 1'b1; wr_data = words[idx];
      end else begin
        wr_valid = 1'($urandom_range(1, 0)); wr_data = W'($urandom);
      end
      hs_pend = wr_valid && wr_ready;
      @(negedge prog_clk);
      cyc++;
    end
    start = 1'b0; wr_valid = 1'b0;
    chk({tag, " finished_in_budget"}, cyc < 3000, 1);
    repeat (2) @(negedge prog_clk);

    chk({tag, " shift_cycles"}, en_cnt - en0, L);
    chk({tag, " words_consumed"}, acc_cnt - acc0, NW);
    chk({tag, " done_pulses"}, done_cnt - dn0, 1);
    chk({tag, " rb_pulses"}, rb_q.size() - rb0, NW);
    exp_vec = '0; got_vec = '0;
    for (int j = 0; j < L; j++) begin
      exp_vec[L-1-j] = words[j / W][W-1-(j % W)];
      if (hq0 + j < head_q.size()) got_vec[L-1-j] = head_q[hq0 + j];
    end
    chk({tag, " head_sequence"}, got_vec, exp_vec);
    chk({tag, " chain_contents"}, chain, exp_vec);
    for (int k = 0; k < NW; k++) begin
      nb = (L - k * W < W) ? L - k * W : W;
      exp_rb = '0;
      for (int b = 0; b < nb; b++) exp_rb[nb-1-b] = snap[L-1-(k*W+b)];
      got_rb = (rb0 + k < rb_q.size()) ? rb_q[rb0 + k] : 'x;
      chk($sformatf("%s rb_word%0d", tag, k), got_rb, exp_rb);
    end
    $display("load %s: mischief=%0d shifts=%0d words=%0d rb=%0d", tag, mischief,
             en_cnt - en0, acc_cnt - acc0, rb_q.size() - rb0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pReset = 1'b1; start = 1'b1; wr_valid = 1'b0; wr_data = '0;
    repeat (2) @(negedge prog_clk);
    chk("reset wr_ready", wr_ready, 0);
    chk("reset ccff_head", ccff_head, 0);
    chk("reset config_enable", config_enable, 0);
    chk("reset rb_data", rb_data, 0);
    chk("reset rb_valid", rb_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    pReset = 1'b0; start = 1'b0;
    @(negedge prog_clk);
    chk("start_during_reset_ignored", {busy, wr_ready}, 2'b00);
    $display("reset: outputs idle");

    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h90;
    run_load("directed", 0, 0, -1, 0);

    for (int i = 0; i < NW; i++) words[i] = '0;
    exp3[0] = 8'hA5; exp3[1] = 8'h3C; exp3[2] = 8'hFF; exp3[3] = 8'h00; exp3[4] = 8'h09;
    run_load("zeros", 0, 0, -1, 0);
    for (int k = 0; k < NW; k++)
      chk($sformatf("readback_const%0d", k), rb_q[rb_q.size() - NW + k], exp3[k]);

    for (int i = 0; i < NW; i++) words[i] = W'($urandom);
    run_load("stall10", 0, 0, 2, 0);

    for (int i = 0; i < NW; i++) words[i] = W'($urandom);
    run_load("abort", 0, 1, -1, 12);
    run_load("reload", 0, 2, -1, 0);

    for (int i = 0; i < NW; i++) words[i] = W'($urandom);
    run_load("mischief", 1, 0, -1, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NW; i++) words[i] = W'($urandom);
      run_load($sformatf("rand%0d", r), 1'($urandom_range(1, 0)), 4, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
